// File: rtl/ifetch_ctrl.sv
// Program counter and fetch sequencer: holds, multi-cycle stalls, ecall halt
// with debounced resume, alignment fault trap and retired-fetch counter.
module ifetch_ctrl #(
    parameter int                    PC_WIDTH        = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC        = '0,
    parameter int                    ALIGN_BITS      = 2,
    parameter int                    STALL_W         = 4,
    parameter int                    DEBOUNCE_CYCLES = 4,
    parameter int                    COUNT_W         = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] target_pc,
    input  logic                stall_req,
    input  logic [STALL_W-1:0]  stall_cycles,
    input  logic                ecall,
    input  logic                continue_button,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_prev,
    output logic                stalled,
    output logic                halted,
    output logic                fault,
    output logic [COUNT_W-1:0]  fetch_count
);
    typedef enum logic [1:0] {RUN, STALL, HALT, FAULT} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Mask form keeps ALIGN_BITS = 0 legal (mask is zero, check disabled).
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        PC_WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

    state_t              state, state_nxt;
    logic [STALL_W-1:0]  cnt, cnt_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [COUNT_W-1:0]  fc_nxt;
    logic                db, db_prev;
    logic [DB_W-1:0]     db_cnt;
    logic                load, misaligned, release_evt;

    assign misaligned  = |(target_pc & ALIGN_MASK);
    assign release_evt = db_prev & ~db;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        fc_nxt    = fetch_count;
        load      = 1'b0;
        case (state)
            RUN: begin
                if (stall_req) begin
                    cnt_nxt   = stall_cycles;
                    state_nxt = STALL;
                end else if (ecall) begin
                    state_nxt = HALT;
                end else begin
                    load = 1'b1;
                end
            end
            STALL: begin
                if (cnt == '0) load = 1'b1;
                else           cnt_nxt = cnt - 1'b1;
            end
            HALT:    load = release_evt;
            default: ;
        endcase
        if (load) begin
            if (misaligned) begin
                state_nxt = FAULT;
            end else begin
                pc_nxt    = target_pc;
                fc_nxt    = fetch_count + 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            pc          <= RESET_PC;
            pc_prev     <= RESET_PC;
            fetch_count <= '0;
            stalled     <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            db          <= 1'b0;
            db_prev     <= 1'b0;
            db_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pc          <= pc_nxt;
            pc_prev     <= pc;
            fetch_count <= fc_nxt;
            stalled     <= (state_nxt == STALL);
            halted      <= (state_nxt == HALT);
            fault       <= (state_nxt == FAULT);
            db_prev     <= db;
            // db follows the raw button only after an unbroken run of differing samples
            if (continue_button != db) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db     <= continue_button;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end
endmodule
